vi_sync_filt_nc: RTL
====================

// Module: vi_sync_filt_nc
// PURPOSE
//  Multi-channel level synchronizer with configurable flop depth and glitch filter.
//  Each bit of asynchronous 'in' passes through a STAGES-deep sync chain.
//  A per-channel stability counter follows the chain; rise/fall pulses are produced
//  on each filtered transition.
//  Sits at clock-domain entry for slow status/control levels (link-up, LOS, GPIO).
// PARAMETERS
//  SIZE      1     number of independent channels (bits), >=1
//  STAGES    2     sync flops per channel, >=2
//  FILT_CYC  4     consecutive differing samples required before out changes, >=1 (1 = no filter)
//  RST_VAL   '0    SIZE-bit reset value of sync chain and out
// PORTS
//  clk_dst     in   1     destination clock
//  rst_dst     in   1     async reset, active-high
//  in          in   SIZE  asynchronous level inputs
//  out         out  SIZE  synchronized, filtered levels (registered)
//  rise        out  SIZE  1-cycle pulse, out went 0->1 this cycle
//  fall        out  SIZE  1-cycle pulse, out went 1->0 this cycle
//  chg_clr     in   SIZE  clear for chg_sticky (only with VI_SYNC_STICKY_EN)
//  chg_sticky  out  SIZE  latched "any change seen" (only with VI_SYNC_STICKY_EN)
// BEHAVIOUR
//  - Interface: one clock clk_dst; rst_dst is asynchronous, active-high; all flops
//    clear on posedge rst_dst.
//  - Reset values:
//    - sync chain = RST_VAL; out = RST_VAL.
//    - rise = fall = 0; per-channel counter = 0; chg_sticky = 0.
//  - Sync chain: s[0] <= in; s[k] <= s[k-1]; the sample is s[STAGES-1]. No logic
//    between stages.
//  - Filter, per channel, every clk_dst edge:
//    - sample == out: cnt <= 0.
//    - sample != out and cnt == FILT_CYC-1: out <= sample; cnt <= 0.
//    - sample != out otherwise: cnt <= cnt+1.
//    - cnt width = $clog2(FILT_CYC+1), min 1. cnt never exceeds FILT_CYC-1 (no wrap).
//  - Latency: a clean change of in, set up before edge 1, appears on out after edge
//    STAGES+FILT_CYC.
//  - Glitch: a level that holds at the sample for fewer than FILT_CYC cycles never
//    reaches out. The counter restarts from 0 when the sample returns to out.
//  - Edge pulses are registered and asserted in the same cycle out takes its new value.
//    - rise = out_new & ~out_old; fall = ~out_new & out_old.
//    - Each pulse lasts exactly 1 cycle; channels are independent.
//  - Channels are fully independent; multiple channels may toggle in the same cycle.
//  - Reset mid-operation: counts and pulses are dropped immediately and out returns to
//    RST_VAL.
//    - After release, an in level differing from RST_VAL propagates as a normal change
//      (pulse after STAGES+FILT_CYC edges).
//  - No pulse is generated by reset assertion or release itself.
// CONFIGURATION
//  VI_SYNC_STICKY_EN defined:
//  - chg_sticky[i] is set the cycle after rise[i]|fall[i].
//  - chg_sticky[i] is cleared the cycle after chg_clr[i] (synchronous to clk_dst).
//  - Simultaneous set and clear: set wins.
//  VI_SYNC_STICKY_EN undefined: chg_clr and chg_sticky ports are absent and no sticky
//  flops exist.
// TESTING
//  1 Reset with RST_VAL=2'b10, SIZE=2 -> out=2'b10, rise=fall=0 during reset and 1 cycle
//    after release with in=2'b10.
//  2 STAGES=2, FILT_CYC=4, in[0] 0->1 before edge 1 and held -> out[0]=1 and rise[0]=1
//    after edge 6 only; fall=0 throughout.
//  3 FILT_CYC=4, in[0] high for 3 clk periods then low -> out[0] stays 0, rise/fall
//    never pulse, cnt returns to 0.
//  4 SIZE=4, in=4'b0101 -> 4'b1010 in one cycle -> rise=4'b1010 and fall=4'b0101 in the
//    same single cycle.
//  5 in[0] held 1, assert rst_dst mid-count (cnt=2) -> out[0]=0 at once. After release,
//    rise[0] pulses at edge STAGES+FILT_CYC.
//  6 VI_SYNC_STICKY_EN: rise[1] pulse with chg_clr[1]=1 in the sticky-set cycle ->
//    chg_sticky[1]=1. Next cycle chg_clr[1]=1 alone -> chg_sticky[1]=0.

Source files
------------

// File: rtl/vi_sync_filt_nc.sv
// Multi-channel level synchronizer: STAGES-deep sync chain, FILT_CYC glitch filter, rise/fall pulses.
// Optional sticky change flags are built when VI_SYNC_STICKY_EN is defined.
module vi_sync_filt_nc #(
  parameter int              SIZE     = 1,
  parameter int              STAGES   = 2,
  parameter int              FILT_CYC = 4,
  parameter logic [SIZE-1:0] RST_VAL  = '0
) (
  input  logic            clk_dst,
  input  logic            rst_dst,
  input  logic [SIZE-1:0] in,
  output logic [SIZE-1:0] out,
  output logic [SIZE-1:0] rise,
`ifdef VI_SYNC_STICKY_EN
  output logic [SIZE-1:0] fall,
  input  logic [SIZE-1:0] chg_clr,
  output logic [SIZE-1:0] chg_sticky
`else
  output logic [SIZE-1:0] fall
`endif
);

  localparam int CNT_W_RAW = $clog2(FILT_CYC + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYC - 1);

  logic [SIZE-1:0]  sync_q [STAGES];
  logic [SIZE-1:0]  samp;
  logic [SIZE-1:0]  out_nxt;
  logic [CNT_W-1:0] cnt_q   [SIZE];
  logic [CNT_W-1:0] cnt_nxt [SIZE];

  // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
  always_ff @(posedge clk_dst or posedge rst_dst) begin
    if (rst_dst) begin
      for (int k = 0; k < STAGES; k++) sync_q[k] <= RST_VAL;
    end else begin
      sync_q[0] <= in;
      for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign samp = sync_q[STAGES-1];

  // Counter saturates at FILT_CYC-1 and commits the new level on that edge.
  always_comb begin
    out_nxt = out;
    for (int i = 0; i < SIZE; i++) begin
      cnt_nxt[i] = '0;
      if (samp[i] != out[i]) begin
        if (cnt_q[i] == CNT_MAX) out_nxt[i] = samp[i];
        else                     cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_dst or posedge rst_dst) begin
    if (rst_dst) begin
      out  <= RST_VAL;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < SIZE; i++) cnt_q[i] <= '0;
    end else begin
      out  <= out_nxt;
      rise <= out_nxt & ~out;
      fall <= ~out_nxt & out;
      for (int i = 0; i < SIZE; i++) cnt_q[i] <= cnt_nxt[i];
    end
  end

`ifdef VI_SYNC_STICKY_EN
  // Set term is OR-ed in last so a simultaneous clear loses.
  always_ff @(posedge clk_dst or posedge rst_dst) begin
    if (rst_dst) chg_sticky <= '0;
    else         chg_sticky <= (chg_sticky & ~chg_clr) | rise | fall;
  end
`endif

endmodule
